// File: rtl/vALU_pkg.sv
// Shared vALU definitions: SEW codes, mask-expander FSM encoding and elements-per-beat helper.
package vALU_pkg;

   localparam logic [1:0] SEW_8  = 2'd0;
   localparam logic [1:0] SEW_16 = 2'd1;
   localparam logic [1:0] SEW_32 = 2'd2;
   localparam logic [1:0] SEW_64 = 2'd3;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   // Elements carried by one beat of `lanes` byte lanes at the given SEW code.
   function automatic int unsigned epb(input int unsigned lanes, input int unsigned sew);
      return lanes >> sew;
   endfunction

endpackage

// File: rtl/vmask_expand_lane_decode.sv
// Per-byte-lane active-element decode: lane b belongs to element idx + (b >> sew).
module vmask_lane_decode #(
   parameter int unsigned W         = 64,
   parameter int unsigned LANES     = 8,
   parameter int unsigned SEW_WIDTH = 2
) (
   input  logic [W-1:0]         idx,
   input  logic [W-1:0]         vstart,
   input  logic [W-1:0]         count,
   input  logic [SEW_WIDTH-1:0] sew,
   output logic [LANES-1:0]     vec
);

   // One extra bit so idx plus the lane offset cannot wrap.
   localparam int unsigned EW = W + 1;

   for (genvar b = 0; b < LANES; b++) begin : g_lane
      logic [EW-1:0] elem;
      assign elem   = {1'b0, idx} + (EW'(b) >> sew);
      assign vec[b] = (elem >= {1'b0, vstart}) && (elem < {1'b0, count});
   end

endmodule

// File: rtl/vmask_expand.sv
// Count-to-mask expander: one (vl, vstart, sew) command becomes a stream of byte-lane mask beats.
module vmask_expand
   import vALU_pkg::*;
#(
   parameter int unsigned REQ_DATA_WIDTH  = 64,
   parameter int unsigned RESP_DATA_WIDTH = 64,
   parameter int unsigned SEW_WIDTH       = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [SEW_WIDTH-1:0]         in_sew,
   input  logic [REQ_DATA_WIDTH-1:0]    in_count,
   input  logic [REQ_DATA_WIDTH-1:0]    in_vstart,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [RESP_DATA_WIDTH/8-1:0] out_vec,
   output logic                         out_last
);

   localparam int unsigned LANES = RESP_DATA_WIDTH / 8;
   localparam int unsigned W     = REQ_DATA_WIDTH;

   logic [0:0]           state_q, state_d;
   logic [W-1:0]         idx_q, idx_d;
   logic [W-1:0]         count_q, vstart_q;
   logic [SEW_WIDTH-1:0] sew_q;
   logic                 load;
   logic [W-1:0]         epb_w;
   logic                 last_c;
   logic                 run;
   logic [LANES-1:0]     dec_vec;

   assign run    = (state_q == ST_RUN);
   assign epb_w  = W'(epb(LANES, 32'(sew_q)));
   // Remaining-count compare avoids forming idx + EPB, which could overflow.
   assign last_c = (count_q - idx_q) <= epb_w;

   vmask_lane_decode #(
      .W         (W),
      .LANES     (LANES),
      .SEW_WIDTH (SEW_WIDTH)
   ) u_decode (
      .idx    (idx_q),
      .vstart (vstart_q),
      .count  (count_q),
      .sew    (sew_q),
      .vec    (dec_vec)
   );

   // Next-state and index update.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      load    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (in_valid && (in_count != '0)) begin
               state_d = ST_RUN;
               idx_d   = '0;
               load    = 1'b1;
            end
         end
         ST_RUN: begin
            if (out_ready) begin
               if (last_c) state_d = ST_IDLE;
               else        idx_d   = idx_q + epb_w;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         count_q  <= '0;
         vstart_q <= '0;
         sew_q    <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         if (load) begin
            count_q  <= in_count;
            vstart_q <= in_vstart;
            sew_q    <= in_sew;
         end
      end
   end

   // Outputs depend only on flops; the rst term makes in_ready drop during reset.
   assign in_ready  = (state_q == ST_IDLE) & rst;
   assign out_valid = run;
   assign out_vec   = run ? dec_vec : '0;
   assign out_last  = run & last_c;

endmodule

// File: tb/tb_vmask_expand.sv
// Scoreboard bench for vmask_expand: directed commands push expected beats, a monitor pops and compares.
module tb_vmask_expand;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  in_sew = '0;
   logic [63:0] in_count = '0;
   logic [63:0] in_vstart = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [7:0]  out_vec;
   logic        out_last;

   typedef struct packed {
      logic [7:0] vec;
      logic       last;
   } beat_t;

   beat_t q[$];
   int checks = 0;
   int errors = 0;
   int hs_count = 0;

   always #5 clk = ~clk;

   vmask_expand dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sew    (in_sew),
      .in_count  (in_count),
      .in_vstart (in_vstart),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_vec   (out_vec),
      .out_last  (out_last)
   );

   // Monitor: compare presented beat with the queue head; pop only on handshake.
   always @(negedge clk) begin
      if (rst && out_valid) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat vec=%02h last=%0b (queue empty)", out_vec, out_last);
         end else begin
            if (out_vec !== q[0].vec || out_last !== q[0].last) begin
               errors++;
               $display("FAIL beat%0d got vec=%02h last=%0b want vec=%02h last=%0b ready=%0b",
                        hs_count, out_vec, out_last, q[0].vec, q[0].last, out_ready);
            end
            if (out_ready) begin
               void'(q.pop_front());
               hs_count++;
            end
         end
      end
   end

   task automatic expect_eq(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", name, got, want);
      end
   endtask

   task automatic push(input logic [7:0] vec, input logic last);
      beat_t b;
      b.vec  = vec;
      b.last = last;
      q.push_back(b);
   endtask

   // Called at posedge+1; issues one command once the DUT is idle.
   task automatic send(input logic [1:0] sew, input int unsigned cnt, input int unsigned vs);
      int unsigned n = 0;
      while (!in_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      expect_eq("send_in_ready", 64'(in_ready), 64'd1);
      in_valid  = 1'b1;
      in_sew    = sew;
      in_count  = 64'(cnt);
      in_vstart = 64'(vs);
      @(posedge clk); #1;
      in_valid  = 1'b0;
   endtask

   task automatic drain(input int unsigned limit);
      int unsigned n = 0;
      while ((q.size() != 0 || out_valid) && n < limit) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (q.size() != 0 || out_valid) begin
         errors++;
         $display("FAIL drain_timeout pending=%0d out_valid=%0b want 0/0", q.size(), out_valid);
      end
   endtask

   initial begin
      int base;
      #1;
      expect_eq("reset_in_ready", 64'(in_ready), 64'd0);
      expect_eq("reset_out_valid", 64'(out_valid), 64'd0);
      expect_eq("reset_out_vec", 64'(out_vec), 64'd0);
      expect_eq("reset_out_last", 64'(out_last), 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      expect_eq("post_reset_in_ready", 64'(in_ready), 64'd1);

      // 1: count=19, sew=8b, back-to-back
      push(8'hFF, 1'b0); push(8'hFF, 1'b0); push(8'h07, 1'b1);
      send(2'd0, 19, 0);
      expect_eq("t1_first_beat_latency", 64'(out_valid), 64'd1);
      expect_eq("t1_in_ready_run", 64'(in_ready), 64'd0);
      drain(20);

      // 2: count=5, vstart=2, sew=16b; second beat holds only element 4
      push(8'hF0, 1'b0); push(8'h03, 1'b1);
      send(2'd1, 5, 2);
      drain(20);

      // 3: count=3, sew=64b, out_ready toggling
      base = hs_count;
      push(8'hFF, 1'b0); push(8'hFF, 1'b0); push(8'hFF, 1'b1);
      send(2'd3, 3, 0);
      fork
         begin
            repeat (12) begin
               out_ready = ~out_ready;
               @(posedge clk); #1;
            end
         end
         drain(40);
      join
      out_ready = 1'b1;
      expect_eq("t3_handshakes", 64'(hs_count - base), 64'd3);

      // 4: count=0 produces nothing, then count=2 sew=32b
      send(2'd2, 0, 0);
      repeat (3) begin
         expect_eq("t4_no_valid", 64'(out_valid), 64'd0);
         expect_eq("t4_in_ready", 64'(in_ready), 64'd1);
         @(posedge clk); #1;
      end
      push(8'hFF, 1'b1);
      send(2'd2, 2, 0);
      drain(20);

      // 5: vstart beyond count still emits beats, all zero
      push(8'h00, 1'b0); push(8'h00, 1'b1);
      send(2'd0, 10, 12);
      drain(20);

      // 6: reset mid-stream after beat 3
      base = hs_count;
      push(8'hFF, 1'b0); push(8'hFF, 1'b0); push(8'hFF, 1'b0);
      send(2'd0, 64, 0);
      for (int i = 0; i < 50 && hs_count < base + 3; i++) @(posedge clk);
      #2;
      expect_eq("t6_beat4_present", 64'(out_valid), 64'd1);
      rst = 1'b0;
      #1;
      expect_eq("t6_rst_out_valid", 64'(out_valid), 64'd0);
      expect_eq("t6_rst_out_vec", 64'(out_vec), 64'd0);
      expect_eq("t6_rst_out_last", 64'(out_last), 64'd0);
      expect_eq("t6_rst_in_ready", 64'(in_ready), 64'd0);
      expect_eq("t6_handshakes", 64'(hs_count - base), 64'd3);
      @(posedge clk);
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      expect_eq("t6_release_in_ready", 64'(in_ready), 64'd1);
      push(8'h01, 1'b1);
      send(2'd0, 1, 0);
      drain(20);

      expect_eq("final_queue_empty", 64'(q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
